// File: rtl/mmul_parallel_engine_pkg.sv
// Shared types and constants for the mmul_parallel engine: control word,
// flag word, FSM state encoding and the default vector length.
package mmul_parallel_package;

  localparam int mmul_parallel_CNT_LEN = 1024;
  localparam int MMUL_LEN_W = $clog2(mmul_parallel_CNT_LEN) + 1;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_RUN,
    ENG_DRAIN
  } engine_state_t;

  typedef struct packed {
    logic                  clear;
    logic                  enable;
    logic                  start;
    logic                  simple_mul;
    logic [4:0]            shift;
    logic [MMUL_LEN_W-1:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [MMUL_LEN_W-1:0] cnt;
    logic                  busy;
    logic                  done;
  } flags_engine_t;

  // A zero-length job still consumes one element.
  function automatic logic [MMUL_LEN_W-1:0] effective_len(input logic [MMUL_LEN_W-1:0] len);
    return (len == '0) ? MMUL_LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/mmul_parallel_engine_shift_sat.sv
// Arithmetic right shift from accumulator width down to result width.
// With MMUL_PARALLEL_ENGINE_SAT_EN defined the result saturates, otherwise it truncates.
module mmul_parallel_engine_shift_sat #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic signed [ACC_W-1:0]  value,
  input  logic        [4:0]        shift,
  output logic        [DATA_W-1:0] result
);

`ifdef MMUL_PARALLEL_ENGINE_SAT_EN
  logic signed [ACC_W-1:0]      shifted;
  logic        [ACC_W-DATA_W:0] upper;

  // The value fits when every bit above the result sign bit repeats it.
  always_comb begin
    shifted = value >>> shift;
    upper   = shifted[ACC_W-1:DATA_W-1];
    if ((&upper) || !(|upper)) begin
      result = shifted[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    result = DATA_W'(value >>> shift);
  end
`endif

endmodule

// File: rtl/mmul_parallel_engine.sv
// Datapath engine of the mmul_parallel HWPE: joins two operand streams, multiplies,
// then accumulates or emits per-element. Result shaping honours MMUL_PARALLEL_ENGINE_SAT_EN.
module mmul_parallel_engine
  import mmul_parallel_package::*;
#(
  parameter int DATA_W  = 32,
  parameter int ACC_W   = 64,
  parameter int CNT_LEN = mmul_parallel_CNT_LEN,
  parameter int LEN_W   = $clog2(CNT_LEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic              simple_mul_i,
  input  logic [4:0]        shift_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              a_valid_i,
  input  logic              b_valid_i,
  output logic              a_ready_o,
  output logic              b_ready_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [LEN_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PROD_W = 2 * DATA_W;

  ctrl_engine_t  ctrl;
  flags_engine_t flags;
  engine_state_t state_q, state_d;

  logic                     simple_q;
  logic [4:0]               shift_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt_q;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_valid_q;
  logic                     prod_last_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     acc_last_q;
  logic signed [ACC_W-1:0]  shift_in;
  logic [DATA_W-1:0]        shaped;
  logic [DATA_W-1:0]        d_data_q;
  logic                     d_valid_q;

  logic live, stall, start_take, in_ready, beat, last_beat;
  logic load_simple, load_acc, out_load, final_load;

  assign ctrl = '{clear:      clear_i,
                  enable:     enable_i,
                  start:      start_i,
                  simple_mul: simple_mul_i,
                  shift:      shift_i,
                  len:        MMUL_LEN_W'(len_i)};

  assign prod_d   = PROD_W'($signed(a_data_i)) * PROD_W'($signed(b_data_i));
  assign prod_ext = ACC_W'(prod_q);
  assign shift_in = simple_q ? prod_ext : acc_q;

  // Only a pending write into an occupied, unconsumed output register stalls.
  always_comb begin
    live        = ctrl.enable && !ctrl.clear && !rst_i;
    stall       = d_valid_q && !d_ready_i && (simple_q ? prod_valid_q : acc_last_q);
    start_take  = live && ctrl.start && (state_q == ENG_IDLE);
    in_ready    = live && (state_q == ENG_RUN) && (cnt_q < len_q) && !stall;
    beat        = in_ready && a_valid_i && b_valid_i;
    last_beat   = beat && ((cnt_q + LEN_W'(1)) == len_q);
    load_simple = live && simple_q && prod_valid_q && !stall;
    load_acc    = live && !simple_q && acc_last_q && !stall;
    out_load    = load_simple || load_acc;
    final_load  = load_acc || (load_simple && prod_last_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENG_IDLE:  if (start_take) state_d = ENG_RUN;
      ENG_RUN:   if (last_beat)  state_d = ENG_DRAIN;
      ENG_DRAIN: if (final_load) state_d = ENG_IDLE;
      default:   state_d = ENG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl.clear) begin
      state_q <= ENG_IDLE;
    end else if (ctrl.enable) begin
      state_q <= state_d;
    end
  end

  mmul_parallel_engine_shift_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) i_shift_sat (
    .value  (shift_in),
    .shift  (shift_q),
    .result (shaped)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl.clear) begin
      simple_q     <= 1'b0;
      shift_q      <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_q        <= '0;
      acc_last_q   <= 1'b0;
      d_data_q     <= '0;
      d_valid_q    <= 1'b0;
    end else if (ctrl.enable) begin
      if (start_take) begin
        simple_q <= ctrl.simple_mul;
        shift_q  <= ctrl.shift;
        len_q    <= LEN_W'(effective_len(ctrl.len));
        cnt_q    <= '0;
        acc_q    <= '0;
      end

      // Accumulate mode drains the product register every cycle; simple mode only on load.
      if (beat) begin
        cnt_q        <= cnt_q + LEN_W'(1);
        prod_q       <= prod_d;
        prod_valid_q <= 1'b1;
        prod_last_q  <= last_beat;
      end else if (prod_valid_q && (!simple_q || load_simple)) begin
        prod_valid_q <= 1'b0;
        prod_last_q  <= 1'b0;
      end

      if (!simple_q && prod_valid_q) begin
        acc_q <= acc_q + prod_ext;
        if (prod_last_q) acc_last_q <= 1'b1;
      end else if (load_acc) begin
        acc_last_q <= 1'b0;
      end

      if (out_load) begin
        d_data_q  <= shaped;
        d_valid_q <= 1'b1;
      end else if (d_ready_i) begin
        d_valid_q <= 1'b0;
      end
    end
  end

  assign flags = '{cnt:  MMUL_LEN_W'(cnt_q),
                   busy: (state_q != ENG_IDLE),
                   done: final_load};

  assign a_ready_o = in_ready;
  assign b_ready_o = in_ready;
  assign d_data_o  = d_data_q;
  assign d_valid_o = d_valid_q;
  assign cnt_o     = LEN_W'(flags.cnt);
  assign busy_o    = flags.busy;
  assign done_o    = flags.done;

endmodule

// File: tb/tb_mmul_parallel_engine.sv
// Directed bench for mmul_parallel_engine with a result scoreboard; honours
// MMUL_PARALLEL_ENGINE_SAT_EN when computing expected results.
module tb_mmul_parallel_engine;

  localparam int DATA_W  = 32;
  localparam int ACC_W   = 64;
  localparam int CNT_LEN = 1024;
  localparam int LEN_W   = $clog2(CNT_LEN) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic              enable_i = 1'b1;
  logic              start_i = 1'b0;
  logic              simple_mul_i = 1'b0;
  logic [4:0]        shift_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic [DATA_W-1:0] a_data_i = '0;
  logic [DATA_W-1:0] b_data_i = '0;
  logic              a_valid_i = 1'b0;
  logic              b_valid_i = 1'b0;
  logic              a_ready_o;
  logic              b_ready_o;
  logic [DATA_W-1:0] d_data_o;
  logic              d_valid_o;
  logic              d_ready_i = 1'b1;
  logic [LEN_W-1:0]  cnt_o;
  logic              busy_o;
  logic              done_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] a_vec[16];
  logic [31:0] b_vec[16];

  mmul_parallel_engine #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .CNT_LEN (CNT_LEN)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .enable_i     (enable_i),
    .start_i      (start_i),
    .simple_mul_i (simple_mul_i),
    .shift_i      (shift_i),
    .len_i        (len_i),
    .a_data_i     (a_data_i),
    .b_data_i     (b_data_i),
    .a_valid_i    (a_valid_i),
    .b_valid_i    (b_valid_i),
    .a_ready_o    (a_ready_o),
    .b_ready_o    (b_ready_o),
    .d_data_o     (d_data_o),
    .d_valid_o    (d_valid_o),
    .d_ready_i    (d_ready_i),
    .cnt_o        (cnt_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] shapeResult(input logic signed [63:0] v, input logic [4:0] sh);
    logic signed [63:0] s;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = 64'sd2147483647;
    min_v = -64'sd2147483648;
    s = v >>> sh;
`ifdef MMUL_PARALLEL_ENGINE_SAT_EN
    if (s > max_v) return 32'h7FFF_FFFF;
    if (s < min_v) return 32'h8000_0000;
`else
    if (s > max_v || s < min_v) return s[31:0];
`endif
    return s[31:0];
  endfunction

  task automatic pushExpected(input logic simple, input logic [4:0] sh, input int len);
    int n;
    logic signed [63:0] a64, b64, acc;
    n = (len == 0) ? 1 : len;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      a64 = {{32{a_vec[i][31]}}, a_vec[i]};
      b64 = {{32{b_vec[i][31]}}, b_vec[i]};
      if (simple) exp_q.push_back(shapeResult(a64 * b64, sh));
      else acc = acc + a64 * b64;
    end
    if (!simple) exp_q.push_back(shapeResult(acc, sh));
  endtask

  // Config inputs are scrambled right after the pulse so only latched values count.
  task automatic startJob(input logic simple, input logic [4:0] sh, input int len);
    start_i = 1'b1;
    simple_mul_i = simple;
    shift_i = sh;
    len_i = LEN_W'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    simple_mul_i = ~simple;
    shift_i = 5'd3;
    len_i = LEN_W'(7);
  endtask

  task automatic driveBeat(input logic [31:0] a, input logic [31:0] b, output int waited);
    int w;
    w = 0;
    a_data_i = a;
    b_data_i = b;
    a_valid_i = 1'b1;
    b_valid_i = 1'b1;
    #3;
    while (!(a_ready_o && b_ready_o) && w < 100) begin
      @(posedge clk_i); #4;
      w++;
    end
    checkOutput("beat_ready", 64'({a_ready_o, b_ready_o}), 64'd3);
    waited = w;
    @(posedge clk_i); #1;
  endtask

  task automatic applyStimulus(input logic simple, input logic [4:0] sh, input int len, input int mid_action);
    int n;
    int w;
    n = (len == 0) ? 1 : len;
    pushExpected(simple, sh, len);
    startJob(simple, sh, len);
    for (int i = 0; i < n; i++) begin
      if (i == 1 && mid_action == 1) start_i = 1'b1;
      if (i == 1 && mid_action == 2) begin
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        enable_i = 1'b0;
        repeat (3) begin
          #3;
          checkOutput("freeze_ready", 64'(a_ready_o), 64'd0);
          @(posedge clk_i); #1;
        end
        enable_i = 1'b1;
      end
      driveBeat(a_vec[i], b_vec[i], w);
      start_i = 1'b0;
      if (i == 0) checkOutput("first_ready_latency", 64'(w), 64'd0);
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk_i);
      w++;
    end
    #1;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && !clear_i && d_valid_o && d_ready_i) begin
      checkOutput("output_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) checkOutput("d_data", 64'(d_data_o), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    int w;
    $display("[TB] start");
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #3;
    checkOutput("reset_a_ready", 64'(a_ready_o), 64'd0);
    checkOutput("reset_b_ready", 64'(b_ready_o), 64'd0);
    checkOutput("reset_d_valid", 64'(d_valid_o), 64'd0);
    checkOutput("reset_d_data", 64'(d_data_o), 64'd0);
    checkOutput("reset_cnt", 64'(cnt_o), 64'd0);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    @(posedge clk_i); #1;

    $display("[TB] accumulate basic");
    a_vec[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_vec[0:3] = '{32'd5, 32'd6, 32'd7, 32'd8};
    applyStimulus(1'b0, 5'd0, 4, 0);
    #3;
    checkOutput("acc_done_t1", 64'(done_o), 64'd0);
    @(posedge clk_i); #4;
    checkOutput("acc_done_t2", 64'(done_o), 64'd1);
    checkOutput("acc_cnt", 64'(cnt_o), 64'd4);
    checkOutput("acc_busy_at_done", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;

    $display("[TB] simple_mul shift back-to-back");
    a_vec[0:2] = '{32'd8, 32'hFFFF_FFF8, 32'd7};
    b_vec[0:2] = '{32'd1, 32'd1, 32'd1};
    applyStimulus(1'b1, 5'd2, 3, 0);
    waitDrain();
    checkOutput("idle_after_simple", 64'(busy_o), 64'd0);

    $display("[TB] backpressure");
    a_vec[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_vec[0:3] = '{32'd10, 32'd10, 32'd10, 32'd10};
    d_ready_i = 1'b0;
    pushExpected(1'b1, 5'd0, 4);
    startJob(1'b1, 5'd0, 4);
    driveBeat(a_vec[0], b_vec[0], w);
    driveBeat(a_vec[1], b_vec[1], w);
    a_data_i = a_vec[2];
    b_data_i = b_vec[2];
    repeat (5) begin
      #3;
      checkOutput("bp_ready_low", 64'(a_ready_o), 64'd0);
      checkOutput("bp_valid_held", 64'(d_valid_o), 64'd1);
      checkOutput("bp_data_stable", 64'(d_data_o), 64'd10);
      @(posedge clk_i); #1;
    end
    d_ready_i = 1'b1;
    driveBeat(a_vec[2], b_vec[2], w);
    driveBeat(a_vec[3], b_vec[3], w);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    waitDrain();

    $display("[TB] saturation or truncation");
    a_vec[0:1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    b_vec[0:1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    applyStimulus(1'b0, 5'd0, 2, 0);
    waitDrain();

    $display("[TB] len zero");
    a_vec[0] = 32'd5;
    b_vec[0] = 32'd6;
    applyStimulus(1'b0, 5'd0, 0, 0);
    waitDrain();
    checkOutput("len0_cnt", 64'(cnt_o), 64'd1);

    $display("[TB] start during run");
    a_vec[0:2] = '{32'd1, 32'd1, 32'd1};
    b_vec[0:2] = '{32'd2, 32'd2, 32'd2};
    applyStimulus(1'b0, 5'd0, 3, 1);
    waitDrain();
    checkOutput("restart_cnt", 64'(cnt_o), 64'd3);

    $display("[TB] enable freeze");
    a_vec[0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_vec[0:3] = '{32'd5, 32'd6, 32'd7, 32'd8};
    applyStimulus(1'b0, 5'd0, 4, 2);
    waitDrain();

    $display("[TB] clear mid-job");
    startJob(1'b0, 5'd0, 8);
    for (int i = 0; i < 3; i++) driveBeat(32'd9, 32'd9, w);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    #3;
    checkOutput("clear_a_ready", 64'(a_ready_o), 64'd0);
    checkOutput("clear_d_valid", 64'(d_valid_o), 64'd0);
    checkOutput("clear_d_data", 64'(d_data_o), 64'd0);
    checkOutput("clear_cnt", 64'(cnt_o), 64'd0);
    checkOutput("clear_busy", 64'(busy_o), 64'd0);
    checkOutput("clear_done", 64'(done_o), 64'd0);
    @(posedge clk_i); #1;
    a_vec[0] = 32'd3;
    b_vec[0] = 32'd3;
    applyStimulus(1'b0, 5'd0, 1, 0);
    waitDrain();

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
